cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer side of the ALU status-flag interface. Holds the architectural N/Z/C/V flag register written by flag-setting ALU ops such as subtract.
- Evaluates the 4-bit condition field of each incoming instruction against the flags. Issues a registered execute/squash decision one cycle later.
- Sits between decode and execute/writeback in the CPU pipeline. Counts squashed instructions for debug.

Parameters:
- CNT_W, 8, width of the saturating squash counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  instruction present this cycle.
- cond  input  4  condition code of the incoming instruction.
- flags_we  input  1  instruction updates flags (S bit).
- flags_in  input  4  flags from the ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- stall  input  1  hold all state.
- flush  input  1  kill the incoming instruction.
- flags_q  output  4  architectural flag register, same bit order.
- valid_out  output  1  registered: the instruction executes (valid and condition passed).
- squash_out  output  1  registered: the instruction was valid but its condition failed.
- squash_cnt  output  CNT_W  saturating count of squashed instructions.

Behaviour:
- Reset (rst_n low, asynchronous): flags_q=4'b0000, valid_out=0, squash_out=0, squash_cnt=0. Reset takes effect immediately, including mid-stall.
- Condition evaluation is combinational on cond and the current flags_q. Name pass:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C. 4 MI: N. 5 PL: !N. 6 VS: V. 7 VC: !V.
  - 8 HI: C&!Z. 9 LS: !C|Z. A GE: N==V. B LT: N!=V.
  - C GT: !Z&(N==V). D LE: Z|(N!=V). E AL: 1. F NV: 0.
- Latency: one cycle. The decision for an instruction presented at edge k appears on valid_out/squash_out after edge k+1.
- Per rising edge, in priority order:
  - stall=1, flush=0: all registers hold (flags_q, valid_out, squash_out, squash_cnt).
  - flush=1 (overrides stall): valid_out<=0, squash_out<=0. flags_q and squash_cnt hold. No flag write.
  - Otherwise, valid_in=1 and pass=1: valid_out<=1, squash_out<=0. If flags_we, flags_q<=flags_in.
  - Otherwise, valid_in=1 and pass=0: valid_out<=0, squash_out<=1, squash_cnt<=squash_cnt+1 saturating at all-ones. flags_q holds even if flags_we=1.
  - Otherwise, valid_in=0: valid_out<=0, squash_out<=0. flags_q holds; flags_we is ignored.
- valid_out and squash_out are never both 1.
- Back-to-back flag dependence: the flags written at edge k are visible to the instruction evaluated in cycle k+1. No forwarding path is needed because evaluation and write occur in the same stage.
- Only flags_q feeds pass. flags_in never feeds pass, so there is no combinational loop.
- squash_cnt does not wrap. At 2^CNT_W-1 it stays there until reset.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with flags_q=4'b1010 and squash_cnt=5 -> flags_q=0, valid_out=0, squash_out=0, squash_cnt=0 immediately, with no clock edge.
- Flag write then dependent branch: cycle 0 valid_in=1, cond=E, flags_we=1, flags_in=4'b0100 (3-3 result, Z=1). Cycle 1 cond=0 (EQ). -> cycle 1 flags_q=4'b0100, valid_out=1. Cycle 2 valid_out=1. Repeat cycle 1 with cond=1 (NE) -> squash_out=1, squash_cnt=1.
- Signed compares: flags_q=4'b1000 (N=1, V=0). Cycles with cond=A, B, C, D -> valid_out sequence 0,1,0,1; squash_cnt increments by 2.
- Failed flag-setter: flags_q=4'b0000, valid_in=1, cond=0, flags_we=1, flags_in=4'b1111 -> flags_q stays 0000, squash_out=1.
- Stall/flush: stall=1 with valid_in=1, cond=E, flags_we=1 -> all outputs unchanged. stall=1 and flush=1 together -> valid_out=0, flags_q unchanged.
- Saturation: CNT_W=3, present 9 NV instructions -> squash_cnt sequence 1..7 then holds at 7; the NV instructions produce no flag writes.

Source files
------------

// File: rtl/cond_flag_unit.sv
// ---------------------------------------------------------------------------
// cond_flag_unit
//
// Consumer side of the ALU status-flag interface. Holds the architectural
// N/Z/C/V flag register and evaluates each incoming instruction's 4-bit
// condition field against it. The execute/squash decision is registered,
// so it appears one cycle after the instruction is presented. A saturating
// counter records how many instructions were squashed, for debug.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   valid_in    instruction present this cycle
//   cond        condition code of the incoming instruction
//   flags_we    instruction updates flags (S bit)
//   flags_in    flags from the ALU: [3]=N [2]=Z [1]=C [0]=V
//   stall       hold all state
//   flush       kill the incoming instruction (wins over stall)
//   flags_q     architectural flag register, same bit order as flags_in
//   valid_out   registered: instruction executes
//   squash_out  registered: instruction was valid but its condition failed
//   squash_cnt  saturating count of squashed instructions
// ---------------------------------------------------------------------------
module cond_flag_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       cond,
    input  logic             flags_we,
    input  logic [3:0]       flags_in,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       flags_q,
    output logic             valid_out,
    output logic             squash_out,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0]       flags_reg,  flags_next;
    logic             valid_reg,  valid_next;
    logic             squash_reg, squash_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;

    logic flag_n, flag_z, flag_c, flag_v;
    logic pass;

    // Only the registered flags feed the condition check; flags_in never
    // does, so there is no path from the ALU result back into pass.
    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    always_comb begin
        pass = 1'b0;
        case (cond)
            4'h0: pass = flag_z;
            4'h1: pass = !flag_z;
            4'h2: pass = flag_c;
            4'h3: pass = !flag_c;
            4'h4: pass = flag_n;
            4'h5: pass = !flag_n;
            4'h6: pass = flag_v;
            4'h7: pass = !flag_v;
            4'h8: pass = flag_c && !flag_z;
            4'h9: pass = !flag_c || flag_z;
            4'hA: pass = (flag_n == flag_v);
            4'hB: pass = (flag_n != flag_v);
            4'hC: pass = !flag_z && (flag_n == flag_v);
            4'hD: pass = flag_z || (flag_n != flag_v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;  // NV
        endcase
    end

    always_comb begin
        flags_next  = flags_reg;
        valid_next  = valid_reg;
        squash_next = squash_reg;
        cnt_next    = cnt_reg;
        if (flush) begin
            // Killed instruction: no decision, no flag write, no count.
            valid_next  = 1'b0;
            squash_next = 1'b0;
        end else if (stall) begin
            // Everything holds (defaults above).
        end else if (valid_in && pass) begin
            valid_next  = 1'b1;
            squash_next = 1'b0;
            if (flags_we) begin
                flags_next = flags_in;
            end
        end else if (valid_in) begin
            // A squashed flag-setter must not write flags.
            valid_next  = 1'b0;
            squash_next = 1'b1;
            if (!(&cnt_reg)) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            valid_next  = 1'b0;
            squash_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg  <= 4'b0000;
            valid_reg  <= 1'b0;
            squash_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            flags_reg  <= flags_next;
            valid_reg  <= valid_next;
            squash_reg <= squash_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign flags_q    = flags_reg;
    assign valid_out  = valid_reg;
    assign squash_out = squash_reg;
    assign squash_cnt = cnt_reg;

endmodule

// File: tb/tb_cond_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flag_unit
//
// Directed vectors with hand-computed expected outputs. Each driven clock
// edge pushes the expected post-edge outputs into a queue; a monitor pops
// and compares after every rising edge. A second instance with CNT_W=3
// covers counter saturation.
// ---------------------------------------------------------------------------
module tb_cond_flag_unit;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [3:0] cond;
    logic       flags_we;
    logic [3:0] flags_in;
    logic       stall;
    logic       flush;

    logic [3:0] flags_q;
    logic       valid_out;
    logic       squash_out;
    logic [7:0] squash_cnt;

    logic [3:0] sat_flags_q;
    logic       sat_valid_out;
    logic       sat_squash_out;
    logic [2:0] sat_squash_cnt;

    cond_flag_unit #(.CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .cond       (cond),
        .flags_we   (flags_we),
        .flags_in   (flags_in),
        .stall      (stall),
        .flush      (flush),
        .flags_q    (flags_q),
        .valid_out  (valid_out),
        .squash_out (squash_out),
        .squash_cnt (squash_cnt)
    );

    cond_flag_unit #(.CNT_W(3)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .cond       (cond),
        .flags_we   (flags_we),
        .flags_in   (flags_in),
        .stall      (stall),
        .flush      (flush),
        .flags_q    (sat_flags_q),
        .valid_out  (sat_valid_out),
        .squash_out (sat_squash_out),
        .squash_cnt (sat_squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ev;
        logic       es;
        logic [3:0] ef;
        logic [7:0] ec;
        logic       chk_sat;
        logic [2:0] esat;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    logic       sat_en  = 1'b0;
    logic [2:0] sat_exp = 3'd0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endfunction

    // Drive one instruction (called at a falling edge), record the expected
    // outputs after the next rising edge, then move to the next falling edge.
    task automatic step(input string nm, input logic v, input logic [3:0] c,
                        input logic we, input logic [3:0] fi,
                        input logic st, input logic fl,
                        input logic ev, input logic es,
                        input logic [3:0] ef, input logic [7:0] ec);
        exp_t e;
        valid_in = v;
        cond     = c;
        flags_we = we;
        flags_in = fi;
        stall    = st;
        flush    = fl;
        e.name    = nm;
        e.ev      = ev;
        e.es      = es;
        e.ef      = ef;
        e.ec      = ec;
        e.chk_sat = sat_en;
        e.esat    = sat_exp;
        exp_q.push_back(e);
        @(negedge clk);
        $display("txn %-10s v=%0b cond=%h we=%0b fi=%b st=%0b fl=%0b -> exp v=%0b s=%0b f=%b cnt=%0d",
                 nm, v, c, we, fi, st, fl, ev, es, ef, ec);
    endtask

    // Monitor: compares the oldest expectation after each rising edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".valid"},  32'(valid_out),  32'(e.ev));
            chk({e.name, ".squash"}, 32'(squash_out), 32'(e.es));
            chk({e.name, ".flags"},  32'(flags_q),    32'(e.ef));
            chk({e.name, ".cnt"},    32'(squash_cnt), 32'(e.ec));
            if (e.chk_sat) begin
                chk({e.name, ".satcnt"}, 32'(sat_squash_cnt), 32'(e.esat));
                chk({e.name, ".satflg"}, 32'(sat_flags_q),    32'(4'b0000));
            end
            if (valid_out && squash_out) begin
                chk({e.name, ".exclusive"}, 32'(1), 32'(0));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; cond = 4'h0; flags_we = 1'b0; flags_in = 4'h0;
        stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        #2;
        chk("rst0.valid",  32'(valid_out),  32'(0));
        chk("rst0.squash", 32'(squash_out), 32'(0));
        chk("rst0.flags",  32'(flags_q),    32'(0));
        chk("rst0.cnt",    32'(squash_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Flag write, then dependent EQ / NE
        step("al_z",   1, 4'hE, 1, 4'b0100, 0, 0, 1, 0, 4'b0100, 8'd0);
        step("eq",     1, 4'h0, 0, 4'b0000, 0, 0, 1, 0, 4'b0100, 8'd0);
        step("ne",     1, 4'h1, 0, 4'b0000, 0, 0, 0, 1, 4'b0100, 8'd1);
        // Signed compares with N=1 V=0
        step("al_n",   1, 4'hE, 1, 4'b1000, 0, 0, 1, 0, 4'b1000, 8'd1);
        step("ge",     1, 4'hA, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 8'd2);
        step("lt",     1, 4'hB, 0, 4'b0000, 0, 0, 1, 0, 4'b1000, 8'd2);
        step("gt",     1, 4'hC, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 8'd3);
        step("le",     1, 4'hD, 0, 4'b0000, 0, 0, 1, 0, 4'b1000, 8'd3);
        step("mi",     1, 4'h4, 0, 4'b0000, 0, 0, 1, 0, 4'b1000, 8'd3);
        step("pl",     1, 4'h5, 0, 4'b0000, 0, 0, 0, 1, 4'b1000, 8'd4);
        // Unsigned / carry / overflow conditions with C=1 only
        step("al_c",   1, 4'hE, 1, 4'b0010, 0, 0, 1, 0, 4'b0010, 8'd4);
        step("hi",     1, 4'h8, 0, 4'b0000, 0, 0, 1, 0, 4'b0010, 8'd4);
        step("ls",     1, 4'h9, 0, 4'b0000, 0, 0, 0, 1, 4'b0010, 8'd5);
        step("cs",     1, 4'h2, 0, 4'b0000, 0, 0, 1, 0, 4'b0010, 8'd5);
        step("cc",     1, 4'h3, 0, 4'b0000, 0, 0, 0, 1, 4'b0010, 8'd6);
        step("vs",     1, 4'h6, 0, 4'b0000, 0, 0, 0, 1, 4'b0010, 8'd7);
        step("vc",     1, 4'h7, 0, 4'b0000, 0, 0, 1, 0, 4'b0010, 8'd7);
        // Failed flag-setter must not write flags; idle ignores flags_we
        step("al_0",   1, 4'hE, 1, 4'b0000, 0, 0, 1, 0, 4'b0000, 8'd7);
        step("eq_we",  1, 4'h0, 1, 4'b1111, 0, 0, 0, 1, 4'b0000, 8'd8);
        step("idle_we",0, 4'hE, 1, 4'b1111, 0, 0, 0, 0, 4'b0000, 8'd8);
        // Stall holds everything; flush overrides stall
        step("al",     1, 4'hE, 0, 4'b0000, 0, 0, 1, 0, 4'b0000, 8'd8);
        step("stl_al", 1, 4'hE, 1, 4'b0110, 1, 0, 1, 0, 4'b0000, 8'd8);
        step("stl_nv", 1, 4'hF, 0, 4'b0000, 1, 0, 1, 0, 4'b0000, 8'd8);
        step("stl_fl", 1, 4'hE, 1, 4'b0110, 1, 1, 0, 0, 4'b0000, 8'd8);
        step("nv",     1, 4'hF, 0, 4'b0000, 0, 0, 0, 1, 4'b0000, 8'd9);
        step("fl_nv",  1, 4'hF, 0, 4'b0000, 0, 1, 0, 0, 4'b0000, 8'd9);
        step("nv2",    1, 4'hF, 0, 4'b0000, 0, 0, 0, 1, 4'b0000, 8'd10);
        step("stl_sq", 1, 4'hF, 0, 4'b0000, 1, 0, 0, 1, 4'b0000, 8'd10);
        step("al_a",   1, 4'hE, 1, 4'b1010, 0, 0, 1, 0, 4'b1010, 8'd10);

        // Asynchronous reset mid-cycle while stalled, no clock edge
        stall = 1'b1; valid_in = 1'b1; cond = 4'hE; flags_we = 1'b1; flags_in = 4'b0101;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid",  32'(valid_out),  32'(0));
        chk("arst.squash", 32'(squash_out), 32'(0));
        chk("arst.flags",  32'(flags_q),    32'(0));
        chk("arst.cnt",    32'(squash_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;

        // Saturation: 9 NV instructions, flags_we set but never taken
        sat_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            sat_exp = (i > 7) ? 3'd7 : 3'(i);
            step("nv_sat", 1, 4'hF, 1, 4'b1111, 0, 0, 0, 1, 4'b0000, 8'(i));
        end
        sat_en = 1'b0;
        step("end",    0, 4'h0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'd9);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                chk("drain", 32'(exp_q.size()), 32'(0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
